hilo_muldiv: RTL
================

# hilo_muldiv

Execute-stage HI/LO unit of the five-stage MIPS core: consumes the 8-bit `alucontrol` code produced by the ID-stage decoder and executes the multiply, divide and HI/LO move class (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO). It owns the architectural HI/LO registers, runs a 32-iteration restoring divider, and stalls the pipeline while a division is in flight. The ALU handles all other codes; this block ignores them.

## Interface
- No parameters; widths are fixed at 32-bit data and 8-bit `alucontrol`.
- clk  in  1  core clock; all state changes on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- valid_i  in  1  an instruction occupies the E stage this cycle.
- flush_i  in  1  exception flush; cancels the current E-stage operation.
- alucontrol  in  8  decoded op: MFHI=8'h10, MTHI=8'h11, MFLO=8'h12, MTLO=8'h13, MULT=8'h18, MULTU=8'h19, DIV=8'h1A, DIVU=8'h1B; all other codes are no-ops.
- src_a  in  32  rs operand (dividend, multiplicand, MTHI/MTLO data).
- src_b  in  32  rt operand (divisor, multiplier).
- stall_o  out  1  hold F/D/E; E-stage instruction must stay presented unchanged.
- result_o  out  32  HI for MFHI, LO for MFLO, else 0; combinational.
- hi_o, lo_o  out  32 each  current HI/LO register contents.

## Operation
- issue = valid_i & ~flush_i. Op codes other than the eight listed: no effect.
- MTHI/MTLO: on issue, HI/LO <= src_a at the end of the cycle.
- MFHI/MFLO: result_o = HI/LO as registered (a write in cycle N is visible from N+1).
- MULT/MULTU: 64-bit product, signed or unsigned; {HI,LO} <= product (see Configuration for latency).
- DIV/DIVU divider FSM, states IDLE, BUSY, DONE:
  - IDLE: issue of DIV/DIVU with src_b != 0 -> latch |src_a|, |src_b| (raw values for DIVU), sign flags; counter <= 0; go BUSY.
  - BUSY: one restoring shift-subtract iteration per cycle; counter increments; after 32 iterations go DONE.
  - DONE: apply signs (quotient negated if sign_a^sign_b; remainder takes sign of src_a); LO <= quotient, HI <= remainder at end of cycle; go IDLE.
- Divisor zero: no FSM start, no stall, HI/LO unchanged.
- stall_o = (IDLE & issue & DIV/DIVU & src_b!=0) | BUSY, forced 0 while flush_i=1.
- flush_i in BUSY or DONE: FSM -> IDLE next edge, HI/LO not written, any pending MULT/MTHI/MTLO write cancelled.
- Reset (resetn=0 at edge, any state, including mid-division): HI=LO=0, FSM IDLE, counter 0, stall_o=0; result_o=0.

## Timing
- Division issued in cycle T0: stall_o high T0..T32 (33 cycles), DONE in T33 (stall_o low, pipeline advances), HI/LO new value visible from T34.
- DONE never restarts a divide even though the same DIV is still presented in E that cycle.
- MTHI/MTLO: single cycle, no stall.
- stall_o and result_o are combinational from state and inputs; no other output paths are combinational.

## Configuration
- HILO_MULT_2CYC_EN defined: MULT/MULTU register operands in the issue cycle, stall_o=1 for that cycle, product written to HI/LO at end of the second cycle (stall low); flush in either cycle cancels the write.
- Undefined: single-cycle combinational multiply, HI/LO written at end of the issue cycle, no stall.

## Test plan
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> stall_o high exactly 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU src_a=0xFFFFFFFF, src_b=0x10 -> LO=0x0FFFFFFF, HI=0x0000000F; DIV/DIVU with src_b=0 -> no stall, HI/LO unchanged.
- MULT 0xFFFFFFFF x 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE; check 0/1 stall cycles per macro.
- MTHI 0x00001234, next cycle MFHI -> result_o=0x00001234; MTLO with flush_i=1 -> LO unchanged.
- DIV issued, flush_i at T10 -> stall_o low in T10, IDLE at T11, HI/LO keep prior values; new DIV at T12 completes normally.
- resetn low at T15 of a division -> HI=LO=0, stall_o=0, FSM IDLE from next cycle.

Source files
------------

// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: E-stage bundle between the pipeline and the HI/LO unit.
// master = pipeline side (drives the decoded op and operands),
// slave  = HI/LO unit (returns stall, move result and HI/LO contents).
interface hilo_muldiv_if;
    logic        valid_i;
    logic        flush_i;
    logic [7:0]  alucontrol;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stall_o;
    logic [31:0] result_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output valid_i, flush_i, alucontrol, src_a, src_b,
        input  stall_o, result_o, hi_o, lo_o
    );

    modport slave (
        input  valid_i, flush_i, alucontrol, src_a, src_b,
        output stall_o, result_o, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: execute-stage HI/LO unit of the five-stage MIPS core.
// Owns HI/LO, performs MULT/MULTU, DIV/DIVU (32-iteration restoring divider)
// and MTHI/MTLO/MFHI/MFLO. Stalls the pipeline while a division runs.
// Optional macro HILO_MULT_2CYC_EN: registers multiply operands in the issue
// cycle (one stall cycle) and writes the product at the end of the next cycle.
module hilo_muldiv (
    input  logic          clk,
    input  logic          resetn,
    hilo_muldiv_if.slave  bus
);
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MTHI  = 8'h11;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_MTLO  = 8'h13;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1A;
    localparam logic [7:0] OP_DIVU  = 8'h1B;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE, ST_MUL} state_t;

    state_t      r_state;
    logic [4:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_divisor;
    logic        r_negQ;
    logic        r_negR;

    logic        w_issue;
    logic        w_isDiv;
    logic        w_isMult;
    logic        w_divSigned;
    logic        w_divStart;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [32:0] w_remShift;
    logic [32:0] w_diff;
    logic [31:0] w_remNext;
    logic [31:0] w_quotNext;
    logic [31:0] w_quotFinal;
    logic [31:0] w_remFinal;
    logic [31:0] w_mulOpA;
    logic [31:0] w_mulOpB;
    logic        w_mulSigned;
    logic [63:0] w_extA;
    logic [63:0] w_extB;
    logic [63:0] w_product;
    logic        w_stall;
    logic [31:0] w_result;

    assign w_issue     = bus.valid_i & ~bus.flush_i;
    assign w_isDiv     = (bus.alucontrol == OP_DIV) | (bus.alucontrol == OP_DIVU);
    assign w_isMult    = (bus.alucontrol == OP_MULT) | (bus.alucontrol == OP_MULTU);
    assign w_divSigned = (bus.alucontrol == OP_DIV);
    assign w_divStart  = (r_state == ST_IDLE) & w_issue & w_isDiv & (bus.src_b != 32'd0);

    assign w_absA = (w_divSigned & bus.src_a[31]) ? (32'd0 - bus.src_a) : bus.src_a;
    assign w_absB = (w_divSigned & bus.src_b[31]) ? (32'd0 - bus.src_b) : bus.src_b;

    // Partial remainder stays below the divisor, so bit 32 of the shifted
    // value is only set when the trial subtraction must succeed.
    assign w_remShift = {r_rem, r_quot[31]};
    assign w_diff     = w_remShift - {1'b0, r_divisor};
    assign w_remNext  = w_diff[32] ? w_remShift[31:0] : w_diff[31:0];
    assign w_quotNext = {r_quot[30:0], ~w_diff[32]};

    assign w_quotFinal = r_negQ ? (32'd0 - r_quot) : r_quot;
    assign w_remFinal  = r_negR ? (32'd0 - r_rem) : r_rem;

`ifdef HILO_MULT_2CYC_EN
    logic [31:0] r_mulA;
    logic [31:0] r_mulB;
    logic        r_mulSigned;

    assign w_mulOpA    = r_mulA;
    assign w_mulOpB    = r_mulB;
    assign w_mulSigned = r_mulSigned;
`else
    assign w_mulOpA    = bus.src_a;
    assign w_mulOpB    = bus.src_b;
    assign w_mulSigned = (bus.alucontrol == OP_MULT);
`endif

    // Sign-extending to 64 bits makes the low 64 product bits correct for both MULT and MULTU.
    assign w_extA    = {{32{w_mulSigned & w_mulOpA[31]}}, w_mulOpA};
    assign w_extB    = {{32{w_mulSigned & w_mulOpB[31]}}, w_mulOpB};
    assign w_product = w_extA * w_extB;

    // HI/LO registers and divider/multiplier sequencing.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_count   <= 5'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_quot    <= 32'd0;
            r_rem     <= 32'd0;
            r_divisor <= 32'd0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
`ifdef HILO_MULT_2CYC_EN
            r_mulA      <= 32'd0;
            r_mulB      <= 32'd0;
            r_mulSigned <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_divStart) begin
                        r_quot    <= w_absA;
                        r_rem     <= 32'd0;
                        r_divisor <= w_absB;
                        r_negQ    <= w_divSigned & (bus.src_a[31] ^ bus.src_b[31]);
                        r_negR    <= w_divSigned & bus.src_a[31];
                        r_count   <= 5'd0;
                        r_state   <= ST_BUSY;
                    end else if (w_issue) begin
                        case (bus.alucontrol)
                            OP_MTHI: r_hi <= bus.src_a;
                            OP_MTLO: r_lo <= bus.src_a;
                            OP_MULT, OP_MULTU: begin
`ifdef HILO_MULT_2CYC_EN
                                r_mulA      <= bus.src_a;
                                r_mulB      <= bus.src_b;
                                r_mulSigned <= (bus.alucontrol == OP_MULT);
                                r_state     <= ST_MUL;
`else
                                r_hi <= w_product[63:32];
                                r_lo <= w_product[31:0];
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    if (bus.flush_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_quot  <= w_quotNext;
                        r_rem   <= w_remNext;
                        r_count <= r_count + 5'd1;
                        if (r_count == 5'd31) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!bus.flush_i) begin
                        r_lo <= w_quotFinal;
                        r_hi <= w_remFinal;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
`ifdef HILO_MULT_2CYC_EN
                    if (!bus.flush_i) begin
                        r_hi <= w_product[63:32];
                        r_lo <= w_product[31:0];
                    end
`endif
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Hold the pipeline while a division starts or runs (and for a two-cycle multiply's issue).
    always_comb begin
        w_stall = 1'b0;
        if (w_divStart || (r_state == ST_BUSY)) begin
            w_stall = 1'b1;
        end
`ifdef HILO_MULT_2CYC_EN
        if ((r_state == ST_IDLE) && w_issue && w_isMult) begin
            w_stall = 1'b1;
        end
`endif
        if (bus.flush_i || !resetn) begin
            w_stall = 1'b0;
        end
    end

    // Move-from result: HI or LO as currently registered, zero for any other op.
    always_comb begin
        w_result = 32'd0;
        if (resetn) begin
            case (bus.alucontrol)
                OP_MFHI: w_result = r_hi;
                OP_MFLO: w_result = r_lo;
                default: w_result = 32'd0;
            endcase
        end
    end

    assign bus.stall_o  = w_stall;
    assign bus.result_o = w_result;
    assign bus.hi_o     = r_hi;
    assign bus.lo_o     = r_lo;
endmodule
